// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port synchronous memory.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-breaking instead of data-over-fetch).
module mem_port_arbiter #(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int   CNT_W     = 2;
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;
    logic              r_if_valid, w_if_valid_nxt;
    logic              r_d_valid, w_d_valid_nxt;
    logic              w_d_req;
    logic              w_pick_d;

    assign w_d_req = d_rd | d_wr;

`ifdef MEM_ARB_RR_EN
    logic r_last_d, w_last_d_nxt;
    // On a tie, data wins only if fetch won the previous tie.
    assign w_pick_d = w_d_req & (~if_req | ~r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_owner_nxt     = r_owner;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_if_valid_nxt  = 1'b0;
        w_d_valid_nxt   = 1'b0;
`ifdef MEM_ARB_RR_EN
        w_last_d_nxt    = r_last_d;
`endif
        case (r_state)
            IDLE: begin
                if (w_d_req | if_req) begin
                    w_owner_nxt    = w_pick_d ? OWN_DATA : OWN_FETCH;
                    w_mem_en_nxt   = 1'b1;
                    w_mem_we_nxt   = w_pick_d & d_wr;
                    w_mem_addr_nxt = w_pick_d ? d_addr : if_addr;
                    if (w_pick_d) begin
                        w_mem_wdata_nxt = d_wdata;
                    end
                    w_state_nxt = RD_WAIT;
`ifdef MEM_ARB_RR_EN
                    if (w_d_req & if_req) begin
                        w_last_d_nxt = w_pick_d;
                    end
`endif
                end
            end
            RD_WAIT: begin
                // First RD_WAIT cycle is the memory issue cycle.
                if (r_mem_en) begin
                    if (r_mem_we) begin
                        w_d_valid_nxt = 1'b1;
                        w_state_nxt   = DONE;
                    end else begin
                        w_cnt_nxt = CNT_W'(READ_LAT - 1);
                    end
                end else if (r_cnt == '0) begin
                    if (r_owner == OWN_DATA) begin
                        w_d_rdata_nxt = mem_rdata;
                        w_d_valid_nxt = 1'b1;
                    end else begin
                        w_if_rdata_nxt = mem_rdata;
                        w_if_valid_nxt = 1'b1;
                    end
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= OWN_FETCH;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_d    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_d_valid   <= w_d_valid_nxt;
`ifdef MEM_ARB_RR_EN
            r_last_d    <= w_last_d_nxt;
`endif
        end
    end

    // Stall drops only in the cycle where every raised request is completing.
    assign stall = (if_req | w_d_req) &
                   ~((~if_req | r_if_valid) & (~w_d_req | r_d_valid));

    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam int AW  = 5;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] pat(input int i);
        return (i == 3) ? 8'hA5 : 8'(i * 37 + 90);
    endfunction

    // Memory macro: synchronous, READ_LAT-cycle read pipeline, junk when no read returns.
    logic [DW-1:0] mem [32];
    logic [DW-1:0] pipe_d [LAT];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= pat(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe_d[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end
    assign mem_rdata = pipe_d[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] ref_mem [32];
    bit ref_last_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction: requests raised together in cycle 0, completion order and
    // timing predicted from the arbitration rule (write 2 cycles, read 2+LAT cycles).
    task automatic run_txn(input bit f, input bit rd, input bit wr,
                           input logic [4:0] fa, input logic [4:0] da,
                           input logic [7:0] wd, input bit early);
        bit dreq, win_d, rf, rq, df, dd, exp_stall;
        int ev_f, ev_d, lat_f, lat_d, iss2, drop_f, drop_d, last;
        logic [4:0] a1, a2;
        logic we1, we2;
        dreq  = rd | wr;
        lat_f = 2 + LAT;
        lat_d = wr ? 2 : 2 + LAT;
        ev_f = -1; ev_d = -1; iss2 = -1;
        a2 = '0; we2 = 1'b0;
        if (dreq && f) begin
`ifdef MEM_ARB_RR_EN
            win_d = !ref_last_d;
            ref_last_d = win_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = dreq;
        end
        if (win_d) begin
            ev_d = lat_d; a1 = da; we1 = wr;
            if (f) begin ev_f = ev_d + 1 + lat_f; iss2 = ev_d + 2; a2 = fa; we2 = 1'b0; end
        end else begin
            ev_f = lat_f; a1 = fa; we1 = 1'b0;
            if (dreq) begin ev_d = ev_f + 1 + lat_d; iss2 = ev_f + 2; a2 = da; we2 = wr; end
        end
        drop_f = (f && !win_d && early) ? 0 : ev_f;
        drop_d = (win_d && early) ? 0 : ev_d;
        last   = ((ev_f > ev_d) ? ev_f : ev_d) + 1;

        if_req = f; if_addr = fa; d_rd = rd; d_wr = wr; d_addr = da; d_wdata = wd;
        for (int k = 0; k <= last; k++) begin
            if (k == 1) begin
                if (win_d) begin
                    d_addr = 5'($urandom); d_wdata = 8'($urandom);
                    if (early) begin d_rd = 1'b0; d_wr = 1'b0; end
                end else begin
                    if_addr = 5'($urandom);
                    if (early) if_req = 1'b0;
                end
            end
            if (f && k == ev_f + 1) if_req = 1'b0;
            if (dreq && k == ev_d + 1) begin d_rd = 1'b0; d_wr = 1'b0; end
            @(negedge clk);
            rf = f && k <= drop_f;
            rq = dreq && k <= drop_d;
            df = f && k == ev_f;
            dd = dreq && k == ev_d;
            exp_stall = (rf || rq) && !((!rf || df) && (!rq || dd));
            chk("if_valid", if_valid, df);
            chk("d_valid", d_valid, dd);
            chk("stall", stall, exp_stall);
            chk("mem_en", mem_en, (k == 1) || (k == iss2));
            if (k == 1) begin
                chk("mem_addr_1", mem_addr, a1);
                chk("mem_we_1", mem_we, we1);
                if (we1) chk("mem_wdata", mem_wdata, wd);
            end
            if (k == iss2) begin
                chk("mem_addr_2", mem_addr, a2);
                chk("mem_we_2", mem_we, we2);
            end
            if (df) chk("if_rdata", if_rdata, ref_mem[fa]);
            if (dd && !wr) chk("d_rdata", d_rdata, ref_mem[da]);
            if (dd && wr) ref_mem[da] = wd;
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        int op;
        bit f, rd, wr;
        for (int i = 0; i < 32; i++) ref_mem[i] = pat(i);
        reset = 1'b0; mem_init = 1'b1;
        if_req = 1'b1; if_addr = 5'd3;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        @(posedge clk); #1;
        mem_init = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_stall", stall, 1);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            @(posedge clk); #1;
        end
        reset = 1'b1;

        run_txn(1, 0, 0, 5'd3, 5'd0, 8'h00, 0);
        run_txn(0, 0, 1, 5'd0, 5'd7, 8'h3C, 0);
        run_txn(0, 1, 0, 5'd0, 5'd7, 8'h00, 0);
        run_txn(1, 1, 0, 5'd9, 5'd12, 8'h00, 0);
        run_txn(1, 1, 0, 5'd31, 5'd0, 8'h00, 0);
        run_txn(0, 1, 1, 5'd0, 5'd2, 8'h11, 0);
        @(negedge clk);
        chk("mem2_written", mem[2], 8'h11);
        @(posedge clk); #1;
        run_txn(0, 1, 0, 5'd0, 5'd2, 8'h00, 1);

        // Reset while the read is waiting on the memory: no valid may follow.
        d_rd = 1'b1; d_addr = 5'd20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; d_rd = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; ref_last_d = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            chk("midrst_d_valid", d_valid, 0);
            chk("midrst_if_valid", if_valid, 0);
            chk("midrst_mem_en", mem_en, 0);
            chk("midrst_stall", stall, 0);
            chk("midrst_d_rdata", d_rdata, 0);
            @(posedge clk); #1;
        end

        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 5);
            f  = (op == 0) || (op >= 4);
            rd = (op == 1) || (op == 3) || (op == 4 && $urandom_range(0, 1) == 1);
            wr = (op == 2) || (op == 3) || (op == 5) || (op == 4 && !rd);
            run_txn(f, rd, wr, 5'($urandom), 5'($urandom), 8'($urandom),
                    $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 32x8 synchronous memory between the core's instruction-fetch port and its data (load/store) port.
- Sequences each access and absorbs the memory read latency.
- Drives the core's `stall` input so the PC holds and the A/B registers do not load until the fetched instruction or the loaded data is valid.
- Sits between `core` and the memory macro in the single-cycle top level.

Parameters:
- READ_LAT, 1: memory read latency in cycles (mem_en accepted to mem_rdata valid); legal range 1..4.
- ADDR_W, 5: address width.
- DATA_W, 8: data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- if_req  input  1  fetch request; held high until if_valid.
- if_addr  input  ADDR_W  fetch address (the core's pc).
- if_rdata  output  DATA_W  fetched instruction.
- if_valid  output  1  one-cycle pulse; if_rdata is valid.
- d_rd  input  1  data read request (the core's rd_mem); held until d_valid.
- d_wr  input  1  data write request (the core's wr_mem); held until d_valid.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  read data.
- d_valid  output  1  one-cycle pulse; data access complete.
- stall  output  1  to core; high while any raised request is not yet completed.
- mem_en  output  1  memory access strobe (one cycle per access).
- mem_we  output  1  write enable, qualified by mem_en.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid READ_LAT cycles after mem_en.

Behaviour:
- FSM states: IDLE, RD_WAIT, DONE. All outputs are registered unless noted otherwise.
- Reset (reset=0 at a clk edge):
  - state <= IDLE.
  - mem_en, mem_we, if_valid, d_valid <= 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata <= 0.
  - latency counter <= 0; grant owner <= FETCH.
  - Reset mid-access abandons the access; a late mem_rdata is ignored.
- IDLE, arbitration:
  - d_rd|d_wr has priority over if_req (fixed priority).
  - The winner's address, write data and the owner ID are latched at grant. Later changes to the requester's inputs do not affect the access in flight.
  - mem_en=1 is issued in the grant cycle's next clock (1-cycle issue).
- Write (d_wr):
  - mem_en=1, mem_we=1 for one cycle; state -> DONE.
  - d_valid pulses the following cycle. Total write latency: 2 cycles from request to d_valid.
- Read (d_rd or fetch):
  - mem_en=1, mem_we=0 for one cycle; state -> RD_WAIT.
  - The counter loads READ_LAT-1 and decrements. At 0, mem_rdata is captured into if_rdata or d_rdata (per owner); state -> DONE.
- DONE:
  - Pulse if_valid or d_valid for exactly one cycle; return to IDLE. A new grant is possible the next cycle (no back-to-back in the DONE cycle).
- Simultaneous d_rd and d_wr: treated as a write; the read is dropped and d_valid is pulsed once.
- stall (combinational): (if_req | d_rd | d_wr) & ~(if_valid | d_valid completing the last pending request).
  - Effect: stall stays high through a fetch that is pending behind a data access.
- The requester must keep its request high until its valid pulse. A request dropped before grant is not serviced. A request dropped after grant still completes, and its valid pulse is still emitted.
- Address wrap: addresses are ADDR_W bits; 31+1 wraps to 0 at the core. The arbiter passes addresses unmodified.
- Starvation: with fixed priority, a continuous data request stream starves fetch; this is tolerated in the default build.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last-winner flag toggles priority whenever both ports request in IDLE. The flag resets to "fetch last won", so data wins the first tie.
- Undefined: fixed data-over-fetch priority as above; the flag logic is not synthesized.

Test Plan:
- Reset: hold reset=0 for 2 cycles with if_req=1 -> mem_en=0, if_valid=0, stall=1, all data outputs 0x00; release -> first mem_en one cycle later with mem_addr=if_addr.
- Fetch, READ_LAT=1: memory[3]=0xA5, if_req=1, if_addr=3 -> mem_en at cycle 1, if_rdata=0xA5 and if_valid pulse at cycle 3, stall low in cycle 3.
- Write then read: d_wr=1, d_addr=7, d_wdata=0x3C -> d_valid 2 cycles later; then d_rd=1, d_addr=7 -> d_rdata=0x3C with d_valid.
- Contention: if_req and d_rd raised together (default build) -> data serviced first, then fetch; stall high until if_valid. With MEM_ARB_RR_EN, on a second simultaneous tie -> fetch is serviced first.
- Latency / mid-op reset: READ_LAT=4, read issued, reset=0 asserted during RD_WAIT -> no valid pulse, state IDLE; mem_rdata arriving afterwards is ignored.
- d_rd and d_wr both high, d_wdata=0x11, d_addr=2 -> single write (mem_we=1), exactly one d_valid pulse, memory[2]=0x11.
